// File: rtl/wb_writer.sv
// wb_writer: writeback-side sequencer for the integer register file.
// Merges ALU results and in-order load responses onto one regfile write port
// and keeps a scoreboard of in-flight load destinations that stalls decode.
// Optional feature macro: WB_BYPASS_EN (forward the registered write to the
// decode operands instead of stalling on a same-cycle regfile write).
module wb_writer #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_M,
  input  logic [4:0]  alu_rd_M,
  input  logic [31:0] alu_data_M,
  input  logic        ld_issue_valid,
  output logic        ld_issue_ready,
  input  logic [4:0]  ld_issue_rd,
  input  logic [2:0]  ld_issue_funct3,
  input  logic [1:0]  ld_issue_addr_lo,
  input  logic        ld_resp_valid,
  input  logic [31:0] ld_resp_data,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [31:0] rdata1_D,
  input  logic [31:0] rdata2_D,
  output logic [31:0] rs1_val_D,
  output logic [31:0] rs2_val_D,
  output logic        stall_D,
  output logic [4:0]  rd_W,
  output logic [31:0] Wdata,
  output logic        we_reg_W,
  output logic        err_resp
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  // Pending-load queue storage
  logic [4:0]          r_q_rd   [LQ_DEPTH];
  logic [2:0]          r_q_f3   [LQ_DEPTH];
  logic [1:0]          r_q_alo  [LQ_DEPTH];
  logic [31:0]         r_q_data [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] r_valid;
  logic [LQ_DEPTH-1:0] r_filled;
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [PW-1:0]       r_fill;
  logic [CW-1:0]       r_count;

  // Registered write port and sticky error
  logic [4:0]  r_rd_w;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_err;

  logic                w_push;
  logic                w_fill;
  logic                w_pop;
  logic [31:0]         w_fmt;
  logic [LQ_DEPTH-1:0] w_hit1;
  logic [LQ_DEPTH-1:0] w_hit2;
  logic                w_sb_stall;
  logic                w_wb_match1;
  logic                w_wb_match2;

  // Circular increment; depth need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(LQ_DEPTH - 1)) n = '0;
    else                        n = p + 1'b1;
    return n;
  endfunction

  // Extract and extend the addressed byte/half from the raw aligned word
  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  alo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (alo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = alo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign ld_issue_ready = (r_count < CW'(LQ_DEPTH));
  assign w_push = ld_issue_valid && ld_issue_ready;
  // Fill only targets entries that already exist, never the one being pushed
  assign w_fill = ld_resp_valid && r_valid[r_fill] && !r_filled[r_fill];
  // ALU results take the write port first; a filled head waits otherwise
  assign w_pop  = !alu_valid_M && r_filled[r_head];
  assign w_fmt  = load_format(ld_resp_data, r_q_f3[r_fill], r_q_alo[r_fill]);

  // Scoreboard: compare decode sources against every live entry
  for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_sb
    assign w_hit1[gi] = r_valid[gi] && (r_q_rd[gi] == rs1_D);
    assign w_hit2[gi] = r_valid[gi] && (r_q_rd[gi] == rs2_D);
  end

  assign w_sb_stall  = ((rs1_D != 5'd0) && (|w_hit1)) || ((rs2_D != 5'd0) && (|w_hit2));
  assign w_wb_match1 = r_we && (r_rd_w == rs1_D) && (rs1_D != 5'd0);
  assign w_wb_match2 = r_we && (r_rd_w == rs2_D) && (rs2_D != 5'd0);

`ifdef WB_BYPASS_EN
  assign rs1_val_D = w_wb_match1 ? r_wdata : rdata1_D;
  assign rs2_val_D = w_wb_match2 ? r_wdata : rdata2_D;
  assign stall_D   = w_sb_stall;
`else
  // Regfile has no internal bypass, so a same-cycle write must be waited out
  assign rs1_val_D = rdata1_D;
  assign rs2_val_D = rdata2_D;
  assign stall_D   = w_sb_stall || w_wb_match1 || w_wb_match2;
`endif

  assign rd_W     = r_rd_w;
  assign Wdata    = r_wdata;
  assign we_reg_W = r_we;
  assign err_resp = r_err;

  // Queue state: push at tail, fill oldest unfilled, pop filled head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        r_q_rd[i]   <= '0;
        r_q_f3[i]   <= '0;
        r_q_alo[i]  <= '0;
        r_q_data[i] <= '0;
      end
      r_valid  <= '0;
      r_filled <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_fill   <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_rd[r_tail]   <= ld_issue_rd;
        r_q_f3[r_tail]   <= ld_issue_funct3;
        r_q_alo[r_tail]  <= ld_issue_addr_lo;
        r_valid[r_tail]  <= 1'b1;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= ptr_inc(r_tail);
      end
      if (w_fill) begin
        r_q_data[r_fill] <= w_fmt;
        r_filled[r_fill] <= 1'b1;
        r_fill           <= ptr_inc(r_fill);
      end
      if (w_pop) begin
        r_valid[r_head]  <= 1'b0;
        r_filled[r_head] <= 1'b0;
        r_head           <= ptr_inc(r_head);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Register the selected write; address/data hold when nothing retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_w  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (alu_valid_M) begin
      r_rd_w  <= alu_rd_M;
      r_wdata <= alu_data_M;
      r_we    <= (alu_rd_M != 5'd0);
    end else if (w_pop) begin
      r_rd_w  <= r_q_rd[r_head];
      r_wdata <= r_q_data[r_head];
      r_we    <= (r_q_rd[r_head] != 5'd0);
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Sticky flag for a response with nothing left to fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_err <= 1'b0;
    else if (ld_resp_valid && !w_fill) r_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: table-driven load formatting vectors, directed corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_wb_writer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_M;
  logic [4:0]  alu_rd_M;
  logic [31:0] alu_data_M;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_addr_lo;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  rs1_D, rs2_D;
  logic [31:0] rdata1_D, rdata2_D;
  logic [31:0] rs1_val_D, rs2_val_D;
  logic        stall_D;
  logic [4:0]  rd_W;
  logic [31:0] Wdata;
  logic        we_reg_W;
  logic        err_resp;

  wb_writer #(.LQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_M(alu_valid_M), .alu_rd_M(alu_rd_M), .alu_data_M(alu_data_M),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
    .ld_issue_rd(ld_issue_rd), .ld_issue_funct3(ld_issue_funct3),
    .ld_issue_addr_lo(ld_issue_addr_lo),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rdata1_D(rdata1_D), .rdata2_D(rdata2_D),
    .rs1_val_D(rs1_val_D), .rs2_val_D(rs2_val_D), .stall_D(stall_D),
    .rd_W(rd_W), .Wdata(Wdata), .we_reg_W(we_reg_W), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a queue of pending loads plus the visible write port
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] data;
    bit          filled;
  } ent_t;
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  logic        m_err;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] raw;
    logic [31:0] exp;
  } fvec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] alo);
    int unsigned bv, hv;
    bv = (w >> (8 * alo)) & 32'hFF;
    hv = (w >> (16 * (alo / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (bv >= 128) ? 32'(bv - 256) : 32'(bv);
      3'b001:  return (hv >= 32768) ? 32'(hv - 65536) : 32'(hv);
      3'b100:  return 32'(bv);
      3'b101:  return 32'(hv);
      default: return w;
    endcase
  endfunction

  function automatic bit pending(input logic [4:0] r);
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0; m_rd = '0; m_wdata = '0; m_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_update();
    bit pre_ready, pop;
    int k;
    ent_t e;
    pre_ready = (mq.size() < DEPTH);
    pop = !alu_valid_M && (mq.size() > 0) && mq[0].filled;
    if (ld_resp_valid) begin
      k = -1;
      foreach (mq[i]) if (k < 0 && !mq[i].filled) k = i;
      if (k >= 0) begin
        mq[k].data   = ref_fmt(ld_resp_data, mq[k].f3, mq[k].alo);
        mq[k].filled = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (alu_valid_M) begin
      m_we = (alu_rd_M != 0); m_rd = alu_rd_M; m_wdata = alu_data_M;
    end else if (pop) begin
      e = mq.pop_front();
      m_we = (e.rd != 0); m_rd = e.rd; m_wdata = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (ld_issue_valid && pre_ready) begin
      e.rd = ld_issue_rd; e.f3 = ld_issue_funct3; e.alo = ld_issue_addr_lo;
      e.data = '0; e.filled = 1'b0;
      mq.push_back(e);
    end
  endtask

  // One cycle: check combinational outputs, clock, check registered outputs
  task automatic step();
    logic m1, m2, e_stall;
    logic [31:0] e_v1, e_v2;
    #1;
    m1 = m_we && (m_rd == rs1_D) && (rs1_D != 0);
    m2 = m_we && (m_rd == rs2_D) && (rs2_D != 0);
    e_stall = ((rs1_D != 0) && pending(rs1_D)) || ((rs2_D != 0) && pending(rs2_D));
`ifdef WB_BYPASS_EN
    e_v1 = m1 ? m_wdata : rdata1_D;
    e_v2 = m2 ? m_wdata : rdata2_D;
`else
    e_v1 = rdata1_D;
    e_v2 = rdata2_D;
    e_stall = e_stall || m1 || m2;
`endif
    chk("ready", ld_issue_ready, (mq.size() < DEPTH));
    chk("stall", stall_D, e_stall);
    chk("rs1_val", rs1_val_D, e_v1);
    chk("rs2_val", rs2_val_D, e_v2);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    chk("we", we_reg_W, m_we);
    chk("rd_W", rd_W, m_rd);
    chk("Wdata", Wdata, m_wdata);
    chk("err", err_resp, m_err);
    $display("cyc %0d alu=%b iss=%b resp=%b -> we=%b rd=%0d wdata=%h stall=%b err=%b q=%0d",
             cyc, alu_valid_M, ld_issue_valid, ld_resp_valid, we_reg_W, rd_W, Wdata,
             stall_D, err_resp, mq.size());
  endtask

  task automatic idle();
    alu_valid_M = 0; ld_issue_valid = 0; ld_resp_valid = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, we_reg_W, 0);
    chk({tag, "_rd"}, rd_W, 0);
    chk({tag, "_wdata"}, Wdata, 0);
    chk({tag, "_err"}, err_resp, 0);
    chk({tag, "_ready"}, ld_issue_ready, 1);
  endtask

  fvec_t fv[11];

  initial begin
    fv[0]  = '{3'b000, 2'd3, 32'h80FF_FF00, 32'hFFFF_FF80};
    fv[1]  = '{3'b101, 2'd2, 32'h80FF_FF00, 32'h0000_80FF};
    fv[2]  = '{3'b100, 2'd1, 32'h80FF_FF00, 32'h0000_00FF};
    fv[3]  = '{3'b001, 2'd0, 32'h80FF_FF00, 32'hFFFF_FF00};
    fv[4]  = '{3'b000, 2'd0, 32'h80FF_FF00, 32'h0000_0000};
    fv[5]  = '{3'b010, 2'd1, 32'h80FF_FF00, 32'h80FF_FF00};
    fv[6]  = '{3'b111, 2'd1, 32'h80FF_FF00, 32'h80FF_FF00};
    fv[7]  = '{3'b001, 2'd2, 32'h7FFF_1234, 32'h0000_7FFF};
    fv[8]  = '{3'b000, 2'd2, 32'h1234_5678, 32'h0000_0034};
    fv[9]  = '{3'b100, 2'd3, 32'hF000_0000, 32'h0000_00F0};
    fv[10] = '{3'b001, 2'd3, 32'h8000_1111, 32'hFFFF_8000};

    rst = 1; idle();
    alu_rd_M = 0; alu_data_M = 0; ld_issue_rd = 0; ld_issue_funct3 = 0;
    ld_issue_addr_lo = 0; ld_resp_data = 0; rs1_D = 0; rs2_D = 0;
    rdata1_D = 32'hAAAA_0001; rdata2_D = 32'hBBBB_0002;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;

    // ALU write appears the next cycle; x0 never writes
    alu_valid_M = 1; alu_rd_M = 5; alu_data_M = 32'h1234;
    step();
    chk("alu5_we", we_reg_W, 1); chk("alu5_rd", rd_W, 5); chk("alu5_data", Wdata, 32'h1234);
    alu_rd_M = 0; alu_data_M = 32'h5555;
    step();
    chk("alu0_we", we_reg_W, 0);
    idle(); step();

    // Formatting vectors: issue, respond, write visible two cycles after response
    for (int i = 0; i < 11; i++) begin
      ld_issue_valid = 1; ld_issue_rd = 7; ld_issue_funct3 = fv[i].f3;
      ld_issue_addr_lo = fv[i].alo;
      step(); idle();
      ld_resp_valid = 1; ld_resp_data = fv[i].raw;
      step(); idle();
      step();
      chk($sformatf("fmt%0d_data", i), Wdata, fv[i].exp);
      chk($sformatf("fmt%0d_rd", i), rd_W, 7);
      chk($sformatf("fmt%0d_we", i), we_reg_W, 1);
    end
    step();

    // Response while ALU holds the port for three cycles
    ld_issue_valid = 1; ld_issue_rd = 9; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 0;
    step(); idle();
    ld_resp_valid = 1; ld_resp_data = 32'hDEAD_BEEF;
    alu_valid_M = 1; alu_rd_M = 3; alu_data_M = 32'h1;
    step(); ld_resp_valid = 0;
    alu_rd_M = 4; alu_data_M = 32'h2; step();
    alu_rd_M = 5; alu_data_M = 32'h3; step();
    chk("hold_alu_rd", rd_W, 5);
    idle(); step();
    chk("hold_ld_rd", rd_W, 9); chk("hold_ld_data", Wdata, 32'hDEAD_BEEF);
    chk("hold_ld_we", we_reg_W, 1);
    step();

    // Full queue: third issue dropped, scoreboard stalls until retire
    ld_issue_valid = 1; ld_issue_funct3 = 3'b010;
    ld_issue_rd = 10; step();
    ld_issue_rd = 11; step();
    ld_issue_rd = 12; rs1_D = 11;
    #1;
    chk("full_ready", ld_issue_ready, 0); chk("full_stall", stall_D, 1);
    step(); idle();
    ld_resp_valid = 1; ld_resp_data = 32'h0000_000A; step();
    ld_resp_data = 32'h0000_000B; step();
    idle(); step(); step();
    #1;
    chk("retired_stall", stall_D, 0);
    chk("empty_ready", ld_issue_ready, 1);
    rs1_D = 0;

    // Write-port match on rs2
    alu_valid_M = 1; alu_rd_M = 6; alu_data_M = 32'hCAFE;
    step(); idle();
    rs2_D = 6; rdata2_D = 32'h1111;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_val", rs2_val_D, 32'hCAFE); chk("byp_stall", stall_D, 0);
`else
    chk("nobyp_val", rs2_val_D, 32'h1111); chk("nobyp_stall", stall_D, 1);
`endif
    step(); rs2_D = 0;

    // Response with empty queue: sticky error
    ld_resp_valid = 1; ld_resp_data = 32'h77; step(); idle();
    step(); step();
    chk("err_sticky", err_resp, 1);

    // Asynchronous reset mid-queue
    ld_issue_valid = 1; ld_issue_rd = 13; step();
    ld_issue_rd = 14; alu_valid_M = 1; alu_rd_M = 2; alu_data_M = 32'h99; step(); idle();
    rs1_D = 13;
    rst = 1; #1;
    check_reset_outputs("midrst");
    chk("midrst_stall", stall_D, 0);
    model_reset();
    @(posedge clk); #1; rst = 0;
    ld_resp_valid = 1; step(); idle();
    chk("late_resp_err", err_resp, 1);
    rs1_D = 0;
    rst = 1; #1; model_reset(); @(posedge clk); #1; rst = 0;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit unf;
      unf = 1'b0;
      foreach (mq[i]) if (!mq[i].filled) unf = 1'b1;
      alu_valid_M      = ($urandom_range(0, 9) < 3);
      alu_rd_M         = 5'($urandom_range(0, 7));
      alu_data_M       = $urandom;
      ld_issue_valid   = ($urandom_range(0, 9) < 4);
      ld_issue_rd      = 5'($urandom_range(0, 7));
      ld_issue_funct3  = 3'($urandom_range(0, 7));
      ld_issue_addr_lo = 2'($urandom_range(0, 3));
      ld_resp_valid    = unf && ($urandom_range(0, 1) == 1);
      ld_resp_data     = $urandom;
      rs1_D            = 5'($urandom_range(0, 7));
      rs2_D            = 5'($urandom_range(0, 7));
      rdata1_D         = $urandom;
      rdata2_D         = $urandom;
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
# wb_writer

Writeback-side writer for the integer register file. Sequences ALU results and in-order load responses into a single regfile write port (`rd_W`/`Wdata`/`we_reg_W`). Tracks in-flight load destinations as a scoreboard that stalls decode. Sits between the memory stage and the register file, beside decode's read ports.

## Interface
- `LQ_DEPTH`, 2: pending-load queue entries (2..8).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid_M` in 1: ALU result valid this cycle.
- `alu_rd_M` in 5: ALU destination.
- `alu_data_M` in 32: ALU result.
- `ld_issue_valid` in 1: load issued; push queue entry.
- `ld_issue_ready` out 1: queue can accept a push (`count < LQ_DEPTH`).
- `ld_issue_rd` in 5: load destination.
- `ld_issue_funct3` in 3: load type.
- `ld_issue_addr_lo` in 2: byte address bits [1:0].
- `ld_resp_valid` in 1: memory read data valid, in issue order.
- `ld_resp_data` in 32: raw aligned word from memory.
- `rs1_D`, `rs2_D` in 5: decode source registers.
- `rdata1_D`, `rdata2_D` in 32: regfile read data.
- `rs1_val_D`, `rs2_val_D` out 32: source operands to decode.
- `stall_D` out 1: decode must hold.
- `rd_W` out 5: regfile write address (registered).
- `Wdata` out 32: regfile write data (registered).
- `we_reg_W` out 1: regfile write enable (registered).
- `err_resp` out 1: sticky; response arrived with no unfilled entry.

## Operation
- Queue entry fields: `rd`, `funct3`, `addr_lo`, `data`, `filled`. Circular buffer with head, tail and fill pointers.
- Push: on `ld_issue_valid && ld_issue_ready`, write at tail with `filled=0`. A push while not ready is dropped.
- Fill: on `ld_resp_valid`, format the data and store it in the oldest unfilled entry, then set `filled`.
  - If no unfilled entry exists, drop the response and set `err_resp`.
  - On a same-cycle push and response, the response fills an existing entry, never the entry being pushed.
- Formatting by `funct3`, selecting the byte/half with `addr_lo`:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half (`addr_lo[1]` selects).
  - 100 LBU, 101 LHU: zero-extend.
  - 010 LW and all other codes: whole word.
- Retire selection, each cycle:
  - `alu_valid_M` has priority: register `{alu_rd_M, alu_data_M}`, `we_reg_W = (alu_rd_M != 0)`.
  - Otherwise, if head is `filled`: pop it, register `{rd, data}`, `we_reg_W = (rd != 0)`.
  - Otherwise `we_reg_W = 0`; `rd_W`/`Wdata` hold their last value.
- x0: entries with `rd=0` still pop but never write.
- Scoreboard: `stall_D = 1` when `rs1_D` or `rs2_D` is nonzero and equals the `rd` of any valid queue entry (filled or not).
- WAW ordering between an ALU write and a pending load to the same `rd` is upstream's job. This block retires as specified with no check.
- `ld_issue_ready` is `count < LQ_DEPTH` from current state only. A same-cycle pop does not free a slot.

## Timing
- Reset values: queue empty, `rd_W=0`, `Wdata=0`, `we_reg_W=0`, `err_resp=0`, `ld_issue_ready=1`.
- Reset mid-operation discards all entries immediately; late responses after reset set `err_resp`.
- ALU result valid in cycle t: `we_reg_W`/`rd_W`/`Wdata` visible in t+1.
- Load response in cycle t: entry filled at end of t; earliest retire selection t+1; write visible t+2. Each cycle with `alu_valid_M` adds one cycle of delay.
- `stall_D`, `rs1_val_D`, `rs2_val_D` are combinational from current state and inputs.
- Queue wraps modulo `LQ_DEPTH`; count width is `$clog2(LQ_DEPTH+1)`.

## Configuration
- `WB_BYPASS_EN` defined: when `we_reg_W && rd_W == rsN_D && rsN_D != 0`, `rsN_val_D = Wdata`; this match does not raise `stall_D`.
- `WB_BYPASS_EN` undefined: `rsN_val_D = rdataN_D` unconditionally; that same match asserts `stall_D` for one cycle, because the regfile has no internal bypass.

## Test plan
- Reset release, ALU `rd=5`, data `0x1234` in cycle 1 -> cycle 2: `we_reg_W=1`, `rd_W=5`, `Wdata=0x1234`; `alu_rd_M=0` -> `we_reg_W=0`.
- Issue LB `rd=7`, `addr_lo=3`; response `0x80FF_FF00` -> write `rd=7`, `0xFFFF_FF80` two cycles after response. The same flow with LHU, `addr_lo=2` -> `0x0000_80FF`.
- Response and ALU valid in the same cycle, ALU held 3 cycles -> three ALU writes first, then the load write in the following cycle.
- Fill queue (2 issues, no responses) -> `ld_issue_ready=0`, third issue dropped. `rs1_D` equal to a pending `rd` -> `stall_D=1` until that entry retires.
- Response with empty queue -> `err_resp=1` and stays 1. Assert `rst` mid-queue -> all outputs at reset values within the same cycle.
- `rs2_D == rd_W` during a write -> with the macro, `rs2_val_D = Wdata` and no stall; without it, `stall_D=1`.
